intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 146 ++++++++++++++
 tb/tb_intr_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Brief    : Memory-mapped fixed-priority interrupt controller (PEND/EN/CLAIM/DONE).
// Option   : define INTR_CTRL_EDGE_EN for rising-edge capture; default is level capture.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
  parameter int          NSRC = 8,
  parameter logic [31:0] BASE = 32'hffff0050
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_we,
  input  logic [31:0]     mem_addr,
  inout  wire  [31:0]     mem_data,
  input  logic [NSRC-1:0] irq_src,
  output logic            cpu_int,
  output logic [4:0]      int_id
);

  localparam logic [31:0] C_ADDR_PEND  = BASE;
  localparam logic [31:0] C_ADDR_EN    = BASE + 32'h4;
  localparam logic [31:0] C_ADDR_CLAIM = BASE + 32'h8;
  localparam logic [31:0] C_ADDR_DONE  = BASE + 32'hc;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SIGNAL = 2'd1,
    SERVE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_en;
  logic [NSRC-1:0] w_event;
  logic [NSRC-1:0] w_clear;
  logic [NSRC-1:0] w_active;
  logic            w_sel_pend;
  logic            w_sel_en;
  logic            w_sel_claim;
  logic            w_sel_done;
  logic            w_claim;
  logic            w_done;
  logic            w_has_win;
  logic [4:0]      w_win;
  logic [31:0]     w_rdata;
  logic            w_drive;
  logic            unused_bits;

  assign w_sel_pend  = (mem_addr == C_ADDR_PEND);
  assign w_sel_en    = (mem_addr == C_ADDR_EN);
  assign w_sel_claim = (mem_addr == C_ADDR_CLAIM);
  assign w_sel_done  = (mem_addr == C_ADDR_DONE);

  assign w_claim = mem_we && w_sel_claim && (r_state == SIGNAL);
  assign w_done  = mem_we && w_sel_done && (r_state == SERVE) && (mem_data[4:0] == int_id);
  assign w_clear = w_claim ? (NSRC'(1) << int_id) : '0;

`ifdef INTR_CTRL_EDGE_EN
  logic [NSRC-1:0] r_src_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_src_prev <= '0;
    else      r_src_prev <= irq_src;
  end

  assign w_event = irq_src & ~r_src_prev;
`else
  assign w_event = irq_src;
`endif

  // A capture event in the same cycle as a claim clear keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_en   <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clear) | w_event;
      if (mem_we && w_sel_en) r_en <= mem_data[NSRC-1:0];
    end
  end

  assign w_active = r_pend & r_en;

  always_comb begin
    w_win     = '0;
    w_has_win = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win     = 5'(i);
        w_has_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      cpu_int <= 1'b0;
      int_id  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_has_win) begin
            r_state <= SIGNAL;
            cpu_int <= 1'b1;
            int_id  <= w_win;
          end
        end
        SIGNAL: begin
          if (w_claim) begin
            r_state <= SERVE;
            cpu_int <= 1'b0;
          end else if (w_has_win) begin
            int_id  <= w_win;
          end else begin
            r_state <= IDLE;
            cpu_int <= 1'b0;
          end
        end
        SERVE: begin
          if (w_done) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          cpu_int <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_pend)       w_rdata = 32'(r_pend);
    else if (w_sel_en)    w_rdata = 32'(r_en);
    else if (w_sel_claim) w_rdata = {(r_state == SIGNAL), 26'd0, int_id};
  end

  assign w_drive  = rst && !mem_we && (w_sel_pend || w_sel_en || w_sel_claim || w_sel_done);
  assign mem_data = w_drive ? w_rdata : 32'hzzzz_zzzz;

  assign unused_bits = &{1'b0, mem_data};

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// tb_intr_ctrl: vector table, directed corner sequences and random traffic
// compared against a rule-level model of the controller.
module tb_intr_ctrl;
  localparam int          NSRC   = 8;
  localparam logic [31:0] BASE   = 32'hffff0050;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_EN   = BASE + 32'h4;
  localparam logic [31:0] A_CLM  = BASE + 32'h8;
  localparam logic [31:0] A_DONE = BASE + 32'hc;
  localparam logic [31:0] A_NONE = BASE + 32'h100;
  // An undriven bus floats to all-ones through the pullup.
  localparam logic [31:0] FLOAT  = 32'hffff_ffff;
`ifdef INTR_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     tb_data;
  logic            tb_drive;
  wire  [31:0]     mem_data;
  logic [NSRC-1:0] irq_src;
  logic            cpu_int;
  logic [4:0]      int_id;
  int              checks = 0;
  int              failures = 0;

  assign mem_data = tb_drive ? tb_data : 32'hzzzz_zzzz;
  pullup pu_bus (mem_data);

  always #5 clk = ~clk;

  intr_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .irq_src (irq_src),
    .cpu_int (cpu_int),
    .int_id  (int_id)
  );

  // Reference model: pending/enable flags, "signalling" and "serving" flags.
  bit         m_pend [NSRC];
  bit         m_en   [NSRC];
  bit         m_prev [NSRC];
  bit         m_sig;
  bit         m_srv;
  logic [4:0] m_id;

  function automatic void model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 1'b0; m_en[i] = 1'b0; m_prev[i] = 1'b0;
    end
    m_sig = 1'b0; m_srv = 1'b0; m_id = '0;
  endfunction

  function automatic void model_step(logic [NSRC-1:0] s, bit we, logic [31:0] a, logic [31:0] d);
    int win = -1;
    bit claim, done, ev;
    for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
    claim = we && (a == A_CLM) && m_sig;
    done  = we && (a == A_DONE) && m_srv && (d[4:0] == m_id);
    if (claim) m_pend[m_id] = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      ev = EDGE ? (s[i] && !m_prev[i]) : s[i];
      if (ev) m_pend[i] = 1'b1;
      m_prev[i] = s[i];
    end
    if (we && a == A_EN) for (int i = 0; i < NSRC; i++) m_en[i] = d[i];
    if (m_sig) begin
      if (claim) begin m_sig = 1'b0; m_srv = 1'b1; end
      else if (win < 0) m_sig = 1'b0;
      else m_id = 5'(win);
    end else if (m_srv) begin
      if (done) m_srv = 1'b0;
    end else if (win >= 0) begin
      m_sig = 1'b1; m_id = 5'(win);
    end
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [31:0] v = '0;
    if (a == A_PEND) begin
      for (int i = 0; i < NSRC; i++) v[i] = m_pend[i];
    end else if (a == A_EN) begin
      for (int i = 0; i < NSRC; i++) v[i] = m_en[i];
    end else if (a == A_CLM) begin
      v = {m_sig, 26'd0, m_id};
    end else if (a != A_DONE) begin
      v = FLOAT;
    end
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(logic [NSRC-1:0] s, bit we, logic [31:0] a, logic [31:0] d);
    irq_src = s; mem_we = we; mem_addr = a; tb_data = d; tb_drive = we;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(irq_src, mem_we, mem_addr, tb_data);
    #1;
    check("model cpu_int", 32'(cpu_int), 32'(m_sig));
    check("model int_id", 32'(int_id), 32'(m_id));
  endtask

  task automatic cyc(logic [NSRC-1:0] s, bit we, logic [31:0] a, logic [31:0] d);
    drive(s, we, a, d);
    tick();
  endtask

  task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
    drive('0, 1'b0, a, '0);
    #1;
    check(name, mem_data, exp);
    tick();
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, cpu_int, int_id};
  endfunction

  // Reset is asserted between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    drive('0, 1'b0, A_PEND, '0);
    rst = 1'b0;
    #1;
    model_reset();
    check("reset cpu_int/int_id", outs(), 32'h0);
    check("reset bus float", mem_data, FLOAT);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit              we;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [NSRC-1:0] src;
    logic [31:0]     rd;
    logic [5:0]      out;
  } vec_t;

  vec_t vec [22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{1'b1, A_EN,   32'h1,         8'h00, FLOAT,         6'h00};
    vec[1]  = '{1'b0, A_NONE, 32'h0,         8'h01, FLOAT,         6'h00};
    vec[2]  = '{1'b0, A_PEND, 32'h0,         8'h00, 32'h1,         6'h20};
    vec[3]  = '{1'b0, A_CLM,  32'h0,         8'h00, 32'h8000_0000, 6'h20};
    vec[4]  = '{1'b1, A_CLM,  32'h0,         8'h00, FLOAT,         6'h00};
    vec[5]  = '{1'b0, A_PEND, 32'h0,         8'h00, 32'h0,         6'h00};
    vec[6]  = '{1'b1, A_DONE, 32'h0,         8'h00, FLOAT,         6'h00};
    vec[7]  = '{1'b0, A_DONE, 32'h0,         8'h00, 32'h0,         6'h00};
    vec[8]  = '{1'b1, A_EN,   32'h0,         8'h00, FLOAT,         6'h00};
    vec[9]  = '{1'b0, A_NONE, 32'h0,         8'h02, FLOAT,         6'h00};
    vec[10] = '{1'b0, A_PEND, 32'h0,         8'h00, 32'h2,         6'h00};
    vec[11] = '{1'b1, A_EN,   32'h2,         8'h00, FLOAT,         6'h00};
    vec[12] = '{1'b0, A_EN,   32'h0,         8'h00, 32'h2,         6'h21};
    vec[13] = '{1'b0, A_CLM,  32'h0,         8'h00, 32'h8000_0001, 6'h21};
    vec[14] = '{1'b1, A_CLM,  32'h0,         8'h00, FLOAT,         6'h01};
    vec[15] = '{1'b0, A_CLM,  32'h0,         8'h00, 32'h1,         6'h01};
    vec[16] = '{1'b1, A_DONE, 32'h1,         8'h00, FLOAT,         6'h01};
    vec[17] = '{1'b1, A_PEND, 32'hff,        8'h00, FLOAT,         6'h01};
    vec[18] = '{1'b0, A_PEND, 32'h0,         8'h00, 32'h0,         6'h01};
    vec[19] = '{1'b1, A_EN,   32'hffff_ffff, 8'h00, FLOAT,         6'h01};
    vec[20] = '{1'b0, A_EN,   32'h0,         8'h00, 32'hff,        6'h01};
    vec[21] = '{1'b0, A_NONE, 32'h0,         8'h00, FLOAT,         6'h01};

    do_reset();
    foreach (vec[k]) begin
      drive(vec[k].src, vec[k].we, vec[k].addr, vec[k].data);
      if (!vec[k].we) begin
        #1;
        check($sformatf("vec%0d read", k), mem_data, vec[k].rd);
      end
      tick();
      check($sformatf("vec%0d outputs", k), outs(), {26'd0, vec[k].out});
    end

    // Higher-priority arrival while signalling, then re-signal after done.
    do_reset();
    cyc('0, 1'b1, A_EN, 32'h5);
    cyc(8'h04, 1'b0, A_NONE, '0);
    cyc(8'h01, 1'b0, A_NONE, '0);  check("preempt first id2", outs(), 32'h22);
    cyc('0, 1'b0, A_NONE, '0);     check("preempt to id0", outs(), 32'h20);
    cyc('0, 1'b1, A_CLM, '0);      check("preempt claim", outs(), 32'h00);
    rd("preempt pend after claim", A_PEND, 32'h4);
    cyc('0, 1'b1, A_DONE, 32'h0);  check("preempt done gap", outs(), 32'h00);
    cyc('0, 1'b0, A_NONE, '0);     check("preempt resignal id2", outs(), 32'h22);

    // Mismatched DONE keeps service; matching DONE returns to idle.
    do_reset();
    cyc('0, 1'b1, A_EN, 32'h8);
    cyc(8'h08, 1'b0, A_NONE, '0);
    cyc('0, 1'b0, A_NONE, '0);     check("serve signal id3", outs(), 32'h23);
    cyc('0, 1'b1, A_CLM, '0);      check("serve claim id3", outs(), 32'h03);
    cyc(8'h08, 1'b1, A_DONE, 32'h1); check("serve wrong done", outs(), 32'h03);
    cyc('0, 1'b0, A_NONE, '0);
    cyc('0, 1'b0, A_NONE, '0);     check("serve no nesting", outs(), 32'h03);
    rd("serve claim read", A_CLM, 32'h3);
    cyc('0, 1'b1, A_DONE, 32'h3);  check("serve right done", outs(), 32'h03);
    cyc('0, 1'b0, A_NONE, '0);     check("serve after done", outs(), 32'h23);

    // Source held high across claim and done.
    do_reset();
    cyc('0, 1'b1, A_EN, 32'h1);
    cyc(8'h01, 1'b0, A_NONE, '0);
    cyc(8'h01, 1'b0, A_NONE, '0);  check("hold signal", outs(), 32'h20);
    cyc(8'h01, 1'b1, A_CLM, '0);   check("hold claim", outs(), 32'h00);
    cyc(8'h01, 1'b1, A_DONE, '0);  check("hold done", outs(), 32'h00);
    cyc(8'h01, 1'b0, A_NONE, '0);
    cyc(8'h01, 1'b0, A_NONE, '0);  check("hold re-assert", outs(), EDGE ? 32'h00 : 32'h20);
    repeat (4) cyc(8'h01, 1'b0, A_NONE, '0);

    // Reset during SIGNAL and during SERVE.
    do_reset();
    cyc('0, 1'b1, A_EN, 32'h2);
    cyc(8'h0a, 1'b0, A_NONE, '0);
    cyc('0, 1'b0, A_NONE, '0);     check("pre-reset signal", outs(), 32'h21);
    do_reset();
    cyc('0, 1'b1, A_EN, 32'h2);
    cyc(8'h0a, 1'b0, A_NONE, '0);
    cyc('0, 1'b0, A_NONE, '0);
    cyc('0, 1'b1, A_CLM, '0);      check("pre-reset serve", outs(), 32'h01);
    do_reset();
    rd("post-reset pend", A_PEND, 32'h0);
    rd("post-reset en", A_EN, 32'h0);
    check("post-reset cpu_int", outs(), 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [NSRC-1:0] s;
      logic [31:0]     a;
      logic [31:0]     d;
      int              op;
      s  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      op = int'($urandom_range(0, 9));
      d  = $urandom;
      case (op)
        0: a = A_EN;
        1: a = A_CLM;
        2: begin a = A_DONE; if ($urandom_range(0, 1) == 1) d = {27'd0, m_id}; end
        3: a = A_PEND;
        default: begin
          case ($urandom_range(0, 4))
            0: a = A_PEND;
            1: a = A_EN;
            2: a = A_CLM;
            3: a = A_DONE;
            default: a = A_NONE;
          endcase
        end
      endcase
      drive(s, op < 4, a, d);
      if (op >= 4) begin
        #1;
        check("random read", mem_data, model_read(a));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
